// File: rtl/afvip_intr_pkg.sv
// Shared types and helpers for the AFVIP interrupt controller.
// The AFVIP_INTR_SYNC_EN macro (see afvip_intr_chan) adds input synchronisers.
package afvip_intr_pkg;

    localparam int AFVIP_INTR_MAX_CH = 32;
    localparam int AFVIP_INTR_IDX_W  = $clog2(AFVIP_INTR_MAX_CH);

    typedef enum logic {
        AFVIP_INTR_LEVEL = 1'b0,
        AFVIP_INTR_EDGE  = 1'b1
    } afvip_intr_mode_e;

    // Index of the lowest set bit, or 0 when no bit is set.
    function automatic logic [AFVIP_INTR_IDX_W-1:0] afvip_intr_prio_enc(
        input logic [AFVIP_INTR_MAX_CH-1:0] vec
    );
        logic [AFVIP_INTR_IDX_W-1:0] idx;
        idx = '0;
        for (int i = AFVIP_INTR_MAX_CH - 1; i >= 0; i--) begin
            if (vec[i]) idx = AFVIP_INTR_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/afvip_intr_chan.sv
// One interrupt channel: optional 2-flop synchroniser, edge/level detect,
// sticky pending and overrun. Build with AFVIP_INTR_SYNC_EN to enable the synchroniser.
module afvip_intr_chan
    import afvip_intr_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             src,
    input  afvip_intr_mode_e mode,
    input  logic             clr,
    output logic             pending,
    output logic             overrun
);

    logic s;
    logic s_prev;
    logic edge_evt;
    logic level_evt;

`ifdef AFVIP_INTR_SYNC_EN
    logic sync_q1;
    logic sync_q2;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b0;
            sync_q2 <= 1'b0;
        end else begin
            sync_q1 <= src;
            sync_q2 <= sync_q1;
        end
    end

    assign s = sync_q2;
`else
    assign s = src;
`endif

    assign edge_evt  = (mode == AFVIP_INTR_EDGE)  & s & ~s_prev;
    assign level_evt = (mode == AFVIP_INTR_LEVEL) & s;

    // NOTE: every flop here uses non-blocking assignment so all channels and
    // the top-level output registers see the same pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_prev  <= 1'b0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            s_prev  <= s;
            // A new event beats a simultaneous clear.
            pending <= edge_evt | level_evt | (pending & ~clr);
            overrun <= (edge_evt & pending & ~clr) | (overrun & ~clr);
        end
    end

endmodule

// File: rtl/afvip_intr_ctrl.sv
// Top of the AFVIP interrupt controller: NUM_CH channels, enable masking,
// lowest-index priority and registered outputs. Optional macro: AFVIP_INTR_SYNC_EN.
module afvip_intr_ctrl
    import afvip_intr_pkg::*;
#(
    parameter int NUM_CH = 8,
    parameter int ID_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] irq_src,
    input  logic [NUM_CH-1:0] irq_en,
    input  logic [NUM_CH-1:0] irq_edge,
    input  logic              clr_valid,
    input  logic [NUM_CH-1:0] clr_mask,
    output logic [NUM_CH-1:0] pending,
    output logic [NUM_CH-1:0] overrun,
    output logic              afvip_intr,
    output logic [ID_W-1:0]   irq_id,
    output logic              irq_id_valid
);

    logic [NUM_CH-1:0]            clr;
    logic [NUM_CH-1:0]            active;
    logic [AFVIP_INTR_MAX_CH-1:0] active_ext;
    logic [ID_W-1:0]              id_next;
    logic                         any_active;

    assign clr = {NUM_CH{clr_valid}} & clr_mask;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        afvip_intr_chan u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .src     (irq_src[i]),
            .mode    (afvip_intr_mode_e'(irq_edge[i])),
            .clr     (clr[i]),
            .pending (pending[i]),
            .overrun (overrun[i])
        );
    end

    // Enable only masks the outputs; pending capture is never gated.
    assign active     = pending & irq_en;
    assign active_ext = AFVIP_INTR_MAX_CH'(active);
    assign any_active = |active;
    assign id_next    = ID_W'(afvip_intr_prio_enc(active_ext));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            afvip_intr   <= 1'b0;
            irq_id       <= '0;
            irq_id_valid <= 1'b0;
        end else begin
            afvip_intr   <= any_active;
            irq_id       <= id_next;
            irq_id_valid <= any_active;
        end
    end

endmodule

// File: tb/tb_afvip_intr_ctrl.sv
// Self-checking bench for afvip_intr_ctrl: directed vector table plus
// hand-written reset and synchroniser sequences.
module tb_afvip_intr_ctrl;

    localparam int NUM_CH = 8;
    localparam int ID_W   = 3;
`ifdef AFVIP_INTR_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    logic              clk;
    logic              rst_n;
    logic [NUM_CH-1:0] irq_src;
    logic [NUM_CH-1:0] irq_en;
    logic [NUM_CH-1:0] irq_edge;
    logic              clr_valid;
    logic [NUM_CH-1:0] clr_mask;
    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] overrun;
    logic              afvip_intr;
    logic [ID_W-1:0]   irq_id;
    logic              irq_id_valid;

    int checks = 0;
    int errors = 0;

    afvip_intr_ctrl #(.NUM_CH(NUM_CH)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .irq_src      (irq_src),
        .irq_en       (irq_en),
        .irq_edge     (irq_edge),
        .clr_valid    (clr_valid),
        .clr_mask     (clr_mask),
        .pending      (pending),
        .overrun      (overrun),
        .afvip_intr   (afvip_intr),
        .irq_id       (irq_id),
        .irq_id_valid (irq_id_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] src;
        logic [7:0] en;
        logic [7:0] edge_m;
        logic       cv;
        logic [7:0] cm;
        logic [7:0] exp_pend;
        logic [7:0] exp_ovr;
        logic       exp_intr;
        logic [2:0] exp_id;
        logic       exp_valid;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] src, input logic [7:0] en, input logic [7:0] edge_m,
                         input logic cv, input logic [7:0] cm);
        irq_src   = src;
        irq_en    = en;
        irq_edge  = edge_m;
        clr_valid = cv;
        clr_mask  = cm;
    endtask

    // Advance one clock and land 1 time unit after the rising edge.
    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        //               src    en     edge   cv    cm     pend   ovr    intr  id    valid
        vecs[0]  = '{8'h00, 8'hFF, 8'hFF, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b1, 3'd0, 1'b1}; // clear all
        vecs[1]  = '{8'h00, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0};
        vecs[2]  = '{8'h08, 8'h08, 8'hFF, 1'b0, 8'h00, 8'h08, 8'h00, 1'b0, 3'd0, 1'b0}; // ch3 pulse 1
        vecs[3]  = '{8'h00, 8'h08, 8'hFF, 1'b0, 8'h00, 8'h08, 8'h00, 1'b1, 3'd3, 1'b1};
        vecs[4]  = '{8'h08, 8'h08, 8'hFF, 1'b0, 8'h00, 8'h08, 8'h08, 1'b1, 3'd3, 1'b1}; // ch3 pulse 2
        vecs[5]  = '{8'h00, 8'h08, 8'hFF, 1'b1, 8'h08, 8'h00, 8'h00, 1'b1, 3'd3, 1'b1}; // clear ch3
        vecs[6]  = '{8'h00, 8'h08, 8'hFF, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0};
        vecs[7]  = '{8'h20, 8'h20, 8'hDF, 1'b0, 8'h00, 8'h20, 8'h00, 1'b0, 3'd0, 1'b0}; // ch5 level
        vecs[8]  = '{8'h20, 8'h20, 8'hDF, 1'b1, 8'h20, 8'h20, 8'h00, 1'b1, 3'd5, 1'b1}; // clear ignored
        vecs[9]  = '{8'h00, 8'h20, 8'hDF, 1'b0, 8'h00, 8'h20, 8'h00, 1'b1, 3'd5, 1'b1}; // sticky
        vecs[10] = '{8'h00, 8'h20, 8'hDF, 1'b1, 8'h20, 8'h00, 8'h00, 1'b1, 3'd5, 1'b1};
        vecs[11] = '{8'h00, 8'h20, 8'hDF, 1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0};
        vecs[12] = '{8'h02, 8'h02, 8'hFF, 1'b0, 8'h00, 8'h02, 8'h00, 1'b0, 3'd0, 1'b0}; // ch1 set
        vecs[13] = '{8'h00, 8'h02, 8'hFF, 1'b0, 8'h00, 8'h02, 8'h00, 1'b1, 3'd1, 1'b1};
        vecs[14] = '{8'h02, 8'h02, 8'hFF, 1'b1, 8'h02, 8'h02, 8'h00, 1'b1, 3'd1, 1'b1}; // collision
        vecs[15] = '{8'h00, 8'h02, 8'hFF, 1'b1, 8'h02, 8'h00, 8'h00, 1'b1, 3'd1, 1'b1};
        vecs[16] = '{8'h14, 8'h10, 8'hFF, 1'b0, 8'h00, 8'h14, 8'h00, 1'b0, 3'd0, 1'b0}; // ch2+ch4
        vecs[17] = '{8'h00, 8'h10, 8'hFF, 1'b0, 8'h00, 8'h14, 8'h00, 1'b1, 3'd4, 1'b1};
        vecs[18] = '{8'h00, 8'h14, 8'hFF, 1'b0, 8'h00, 8'h14, 8'h00, 1'b1, 3'd2, 1'b1};
        vecs[19] = '{8'h00, 8'h00, 8'hFF, 1'b0, 8'h00, 8'h14, 8'h00, 1'b0, 3'd0, 1'b0}; // all masked
        vecs[20] = '{8'h00, 8'h00, 8'hEF, 1'b0, 8'h00, 8'h14, 8'h00, 1'b0, 3'd0, 1'b0}; // mode change
        vecs[21] = '{8'h00, 8'h00, 8'hEF, 1'b1, 8'hFF, 8'h00, 8'h00, 1'b0, 3'd0, 1'b0}; // wide clear

        // Reset with all edge sources high across release.
        rst_n = 1'b0;
        drive(8'hFF, 8'hFF, 8'hFF, 1'b0, 8'h00);
        tick(2);
        check("rst_pending", 32'(pending), 32'h00);
        check("rst_overrun", 32'(overrun), 32'h00);
        check("rst_intr", 32'(afvip_intr), 32'h0);
        check("rst_id_valid", 32'(irq_id_valid), 32'h0);
        rst_n = 1'b1;
        tick(1 + LAT);
        check("rel_pending", 32'(pending), 32'hFF);
        check("rel_intr_early", 32'(afvip_intr), 32'h0);
        tick(1);
        check("rel_intr", 32'(afvip_intr), 32'h1);
        check("rel_id", 32'(irq_id), 32'h0);
        check("rel_overrun", 32'(overrun), 32'h00);

`ifndef AFVIP_INTR_SYNC_EN
        for (int v = 0; v < NV; v++) begin
            drive(vecs[v].src, vecs[v].en, vecs[v].edge_m, vecs[v].cv, vecs[v].cm);
            tick(1);
            check($sformatf("v%0d_pending", v), 32'(pending), 32'(vecs[v].exp_pend));
            check($sformatf("v%0d_overrun", v), 32'(overrun), 32'(vecs[v].exp_ovr));
            check($sformatf("v%0d_intr", v), 32'(afvip_intr), 32'(vecs[v].exp_intr));
            check($sformatf("v%0d_id", v), 32'(irq_id), 32'(vecs[v].exp_id));
            check($sformatf("v%0d_valid", v), 32'(irq_id_valid), 32'(vecs[v].exp_valid));
        end
`else
        // Synchroniser latency: ch0 edge high before posedge k, intr after k+3.
        drive(8'h00, 8'h01, 8'hFF, 1'b1, 8'hFF);
        tick(4);
        drive(8'h01, 8'h01, 8'hFF, 1'b0, 8'h00);
        tick(1);
        check("sync_pend_k", 32'(pending), 32'h00);
        tick(1);
        check("sync_pend_k1", 32'(pending), 32'h00);
        tick(1);
        check("sync_pend_k2", 32'(pending), 32'h01);
        check("sync_intr_k2", 32'(afvip_intr), 32'h0);
        tick(1);
        check("sync_intr_k3", 32'(afvip_intr), 32'h1);
        check("sync_id_k3", 32'(irq_id), 32'h0);

        // Reset while a pulse is still inside the synchroniser.
        drive(8'h00, 8'h01, 8'hFF, 1'b1, 8'hFF);
        tick(4);
        drive(8'h01, 8'h01, 8'hFF, 1'b0, 8'h00);
        tick(1);
        irq_src = 8'h00;
        rst_n   = 1'b0;
        #2;
        rst_n = 1'b1;
        tick(5);
        check("sync_rst_pend", 32'(pending), 32'h00);
        check("sync_rst_intr", 32'(afvip_intr), 32'h0);
`endif

        // Asynchronous reset in the middle of operation.
        drive(8'h00, 8'hFF, 8'hFF, 1'b1, 8'hFF);
        tick(LAT + 2);
        drive(8'h01, 8'hFF, 8'hFF, 1'b0, 8'h00);
        tick(LAT + 2);
        check("mid_pend_set", 32'(pending), 32'h01);
        check("mid_intr_set", 32'(afvip_intr), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_pend", 32'(pending), 32'h00);
        check("mid_rst_intr", 32'(afvip_intr), 32'h0);
        check("mid_rst_valid", 32'(irq_id_valid), 32'h0);
        irq_src = 8'h00;
        @(negedge clk);
        rst_n = 1'b1;
        tick(LAT + 2);
        check("mid_post_pend", 32'(pending), 32'h00);
        check("mid_post_intr", 32'(afvip_intr), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
